// File: rtl/interp_pkg.sv
// ============================================================================
// Module   : interp_pkg
// Purpose  : Shared constants, FSM state type and helpers for interp_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package interp_pkg;

  localparam int NUM_TAPS     = 4;
  localparam int NUM_PHASES   = 25;
  localparam int MULT_LATENCY = 1;
  localparam int ADDR_W       = 8;
  localparam int PHASE_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Increment that holds once the last legal address is reached.
  function automatic logic [ADDR_W-1:0] sat_inc(
    input logic [ADDR_W-1:0] value,
    input logic [ADDR_W-1:0] limit
  );
    return (value == limit) ? value : value + ADDR_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/interp_valid_pipe.sv
// ============================================================================
// Module   : interp_valid_pipe
// Purpose  : DEPTH-stage delay line carrying the valid flag and its phase tag
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module interp_valid_pipe #(
  parameter int DEPTH   = 1,
  parameter int PHASE_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PHASE_W-1:0] in_phase,
  output logic               out_valid,
  output logic [PHASE_W-1:0] out_phase
);

  logic [DEPTH-1:0]   r_valid;
  logic [PHASE_W-1:0] r_phase [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_phase[i] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_phase[0] <= in_phase;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_phase[i] <= r_phase[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_phase = r_phase[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/interp_sequencer.sv
// ============================================================================
// Module   : interp_sequencer
// Purpose  : Address/phase sequencer for the 4-tap, 25-phase interpolator
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module interp_sequencer
  import interp_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  frame_len,
  input  logic               out_tick,
  output logic [ADDR_W-1:0]  addr_data,
  output logic [ADDR_W-1:0]  addr_factor,
  output logic               out_valid,
  output logic [PHASE_W-1:0] out_phase,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  localparam logic [ADDR_W-1:0]  c_one        = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  c_taps       = ADDR_W'(NUM_TAPS);
  localparam logic [ADDR_W-1:0]  c_prime_last = ADDR_W'(NUM_TAPS - 1);
  localparam logic [ADDR_W-1:0]  c_drain_last = ADDR_W'(MULT_LATENCY - 1);
  localparam logic [ADDR_W-1:0]  c_shift      = ADDR_W'(NUM_PHASES - 1);
  localparam logic [PHASE_W-1:0] c_last_phase = PHASE_W'(NUM_PHASES - 1);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_len;
  logic [ADDR_W-1:0]  r_cnt;
  logic [ADDR_W-1:0]  r_blk;
  logic [PHASE_W-1:0] r_phase;
  logic [ADDR_W-1:0]  r_addr_data;
  logic [ADDR_W-1:0]  r_addr_factor;
  logic               r_busy;
  logic               r_done;
  logic               r_cfg_err;
  logic               r_issue_valid;
  logic [PHASE_W-1:0] r_issue_phase;

  logic [ADDR_W-1:0]  w_addr_next;
  logic               w_last_block;
  logic               w_shift_now;

  assign w_addr_next  = sat_inc(r_addr_data, r_len - c_one);
  assign w_last_block = (r_blk == (r_len - c_taps));
  // The datapath shifts on the edge that ends a cycle with the top phase.
  assign w_shift_now  = (r_addr_factor == c_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_len         <= '0;
      r_cnt         <= '0;
      r_blk         <= '0;
      r_phase       <= '0;
      r_addr_data   <= '0;
      r_addr_factor <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_issue_valid <= 1'b0;
      r_issue_phase <= '0;
    end else begin
      r_done        <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_issue_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          r_addr_factor <= '0;
          if (start) begin
            if (frame_len < c_taps) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_len         <= frame_len;
              r_addr_data   <= '0;
              r_addr_factor <= c_shift;
              r_cnt         <= '0;
              r_busy        <= 1'b1;
              r_state       <= PRIME;
            end
          end
        end

        PRIME: begin
          if (r_cnt == c_prime_last) begin
            r_addr_data   <= c_taps;
            r_addr_factor <= '0;
            r_phase       <= '0;
            r_blk         <= '0;
            r_state       <= RUN;
          end else begin
            r_cnt         <= r_cnt + c_one;
            r_addr_data   <= r_addr_data + c_one;
            r_addr_factor <= c_shift;
          end
        end

        RUN: begin
          if (w_shift_now) begin
            r_addr_data <= w_addr_next;
          end
          if (out_tick) begin
            r_addr_factor <= ADDR_W'(r_phase);
            r_issue_valid <= 1'b1;
            r_issue_phase <= r_phase;
            if (r_phase == c_last_phase) begin
              r_phase <= '0;
              if (w_last_block) begin
                r_cnt   <= '0;
                r_state <= DRAIN;
              end else begin
                r_blk <= r_blk + c_one;
              end
            end else begin
              r_phase <= r_phase + PHASE_W'(1);
            end
          end else begin
            r_addr_factor <= '0;
          end
        end

        DRAIN: begin
          if (w_shift_now) begin
            r_addr_data <= w_addr_next;
          end
          r_addr_factor <= '0;
          if (r_cnt == c_drain_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + c_one;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  interp_valid_pipe #(
    .DEPTH   (MULT_LATENCY),
    .PHASE_W (PHASE_W)
  ) u_valid_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (r_issue_valid),
    .in_phase  (r_issue_phase),
    .out_valid (out_valid),
    .out_phase (out_phase)
  );

  assign addr_data   = r_addr_data;
  assign addr_factor = r_addr_factor;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cfg_err     = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_interp_sequencer.sv
// ============================================================================
// Module   : tb_interp_sequencer
// Purpose  : Directed self-checking bench for interp_sequencer
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_interp_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] frame_len;
  logic       out_tick;
  logic [7:0] addr_data;
  logic [7:0] addr_factor;
  logic       out_valid;
  logic [4:0] out_phase;
  logic       busy;
  logic       done;
  logic       cfg_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  interp_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_len   (frame_len),
    .out_tick    (out_tick),
    .addr_data   (addr_data),
    .addr_factor (addr_factor),
    .out_valid   (out_valid),
    .out_phase   (out_phase),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the filter datapath: asynchronous source memory, 4-tap
  // delay line shifting on phase 24, registered multiply-accumulate.
  int mem [6] = '{10, 20, 30, 40, 50, 60};
  int taps [4];
  int dataout;

  function automatic int coef(input int p, input int k);
    return ((p * 4 + k) % 7) + 1;
  endfunction

  function automatic int golden(input int b, input int p);
    return mem[b+3] * coef(p, 0) + mem[b+2] * coef(p, 1)
         + mem[b+1] * coef(p, 2) + mem[b]   * coef(p, 3);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      taps    <= '{0, 0, 0, 0};
      dataout <= 0;
    end else begin
      dataout <= taps[0] * coef(int'(addr_factor), 0) + taps[1] * coef(int'(addr_factor), 1)
               + taps[2] * coef(int'(addr_factor), 2) + taps[3] * coef(int'(addr_factor), 3);
      if (addr_factor == 8'd24) begin
        taps[0] <= (int'(addr_data) < 6) ? mem[int'(addr_data)] : 0;
        taps[1] <= taps[0];
        taps[2] <= taps[1];
        taps[3] <= taps[2];
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_tick = 1'b0; frame_len = 8'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({addr_data, addr_factor, out_valid, out_phase, busy, done, cfg_err} !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {addr_data, addr_factor, out_valid, out_phase, busy, done, cfg_err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({addr_data, addr_factor, out_valid, out_phase, busy, done, cfg_err} !== 25'd0) begin
      bad++;
      $display("FAIL idle_outputs: got %h want 0",
               {addr_data, addr_factor, out_valid, out_phase, busy, done, cfg_err});
    end
  endtask

  task automatic test_cfg_err();
    start = 1'b1; frame_len = 8'd3;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_pulse: got %b want 1", cfg_err); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL cfg_err_busy: got %b want 0", busy); end
    total++;
    if ({addr_data, addr_factor} !== 16'd0) begin
      bad++; $display("FAIL cfg_err_addr: got %h want 0", {addr_data, addr_factor});
    end
    @(negedge clk);
    total++;
    if ({cfg_err, busy, addr_data, addr_factor} !== 18'd0) begin
      bad++; $display("FAIL cfg_err_after: got %h want 0", {cfg_err, busy, addr_data, addr_factor});
    end
  endtask

  task automatic test_full_frame();
    int nv, nd, dbl;
    bit prev24;
    nv = 0; nd = 0; dbl = 0; prev24 = 1'b0;
    start = 1'b1; frame_len = 8'd6; out_tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (addr_factor !== 8'd24 || addr_data !== 8'(i) || busy !== 1'b1) begin
        bad++;
        $display("FAIL prime_%0d: got af=%0d ad=%0d busy=%b want af=24 ad=%0d busy=1",
                 i, addr_factor, addr_data, busy, i);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 300 && nd == 0; c++) begin
      if (out_valid) begin
        total++;
        if (out_phase !== 5'(nv % 25)) begin
          bad++; $display("FAIL full_phase_%0d: got %0d want %0d", nv, out_phase, nv % 25);
        end
        nv++;
      end
      if (addr_factor == 8'd24 && prev24) dbl++;
      prev24 = (addr_factor == 8'd24);
      if (done) begin
        nd++;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL full_done_busy: got %b want 0", busy); end
      end else begin
        @(negedge clk);
      end
    end
    out_tick = 1'b0;
    total++;
    if (nd != 1) begin bad++; $display("FAIL full_done_seen: got %0d want 1", nd); end
    total++;
    if (nv != 75) begin bad++; $display("FAIL full_valid_count: got %0d want 75", nv); end
    total++;
    if (dbl != 0) begin bad++; $display("FAIL full_double_24: got %0d want 0", dbl); end
    @(negedge clk);
    total++;
    if ({done, busy, out_valid} !== 3'b000) begin
      bad++; $display("FAIL full_post: got %b want 000", {done, busy, out_valid});
    end
  endtask

  task automatic test_sparse_ticks();
    int q_cyc[$];
    int q_ph[$];
    int nt, nv, nd, dbl, af_at, af_ph, ec, ep;
    bit prev24;
    nt = 0; nv = 0; nd = 0; dbl = 0; af_at = -1; af_ph = 0; prev24 = 1'b0;
    start = 1'b1; frame_len = 8'd4; out_tick = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (addr_factor !== 8'd24 || addr_data !== 8'(i)) begin
        bad++; $display("FAIL sparse_prime_%0d: got af=%0d ad=%0d want 24/%0d", i, addr_factor, addr_data, i);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 400 && nd == 0; c++) begin
      if (cyc == af_at) begin
        total++;
        if (addr_factor !== 8'(af_ph)) begin
          bad++; $display("FAIL sparse_af_%0d: got %0d want %0d", af_ph, addr_factor, af_ph);
        end
      end
      if (out_valid) begin
        total++;
        if (q_cyc.size() == 0) begin
          bad++; $display("FAIL sparse_extra_valid: got valid at cycle %0d want none", cyc);
        end else begin
          ec = q_cyc.pop_front();
          ep = q_ph.pop_front();
          if (cyc != ec || out_phase !== 5'(ep)) begin
            bad++; $display("FAIL sparse_valid_%0d: got cyc=%0d ph=%0d want cyc=%0d ph=%0d",
                            nv, cyc, out_phase, ec, ep);
          end
        end
        nv++;
      end
      if (addr_factor == 8'd24 && prev24) dbl++;
      prev24 = (addr_factor == 8'd24);
      if (done) nd++;
      out_tick = (c % 3 == 0) && (nt < 25);
      if (out_tick) begin
        q_cyc.push_back(cyc + 2);
        q_ph.push_back(nt);
        af_at = cyc + 1;
        af_ph = nt;
        nt++;
      end
      if (nd == 0) @(negedge clk);
    end
    out_tick = 1'b0;
    total++;
    if (nv != 25 || q_cyc.size() != 0) begin
      bad++; $display("FAIL sparse_valid_count: got %0d left=%0d want 25 left=0", nv, q_cyc.size());
    end
    total++;
    if (nd != 1) begin bad++; $display("FAIL sparse_done_seen: got %0d want 1", nd); end
    total++;
    if (dbl != 0) begin bad++; $display("FAIL sparse_double_24: got %0d want 0", dbl); end
    @(negedge clk);
  endtask

  task automatic test_datapath();
    int nv, nd, nt, exp_v;
    nv = 0; nd = 0; nt = 0;
    start = 1'b1; frame_len = 8'd6; out_tick = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 400 && nd == 0; c++) begin
      if (out_valid) begin
        exp_v = golden(nv / 25, nv % 25);
        total++;
        if (dataout != exp_v || out_phase !== 5'(nv % 25)) begin
          bad++; $display("FAIL dp_out_%0d: got data=%0d ph=%0d want data=%0d ph=%0d",
                          nv, dataout, out_phase, exp_v, nv % 25);
        end
        nv++;
      end
      if (done) nd++;
      out_tick = (c % 2 == 0) && (nt < 75);
      if (out_tick) nt++;
      if (nd == 0) @(negedge clk);
    end
    out_tick = 1'b0;
    total++;
    if (nv != 75 || nd != 1) begin
      bad++; $display("FAIL dp_counts: got valids=%0d done=%0d want 75/1", nv, nd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int nv, nd, stray;
    nv = 0; nd = 0; stray = 0;
    start = 1'b1; frame_len = 8'd6; out_tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && nv < 30; c++) begin
      if (out_valid) nv++;
      if (nv < 30) @(negedge clk);
    end
    total++;
    if (nv != 30) begin bad++; $display("FAIL rstmid_reach30: got %0d want 30", nv); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_tick = 1'b0;
    total++;
    if ({addr_data, addr_factor, out_valid, out_phase, busy, done, cfg_err} !== 25'd0) begin
      bad++; $display("FAIL rstmid_clear: got %h want 0",
                      {addr_data, addr_factor, out_valid, out_phase, busy, done, cfg_err});
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (done || out_valid || busy) stray++;
    end
    total++;
    if (stray != 0) begin bad++; $display("FAIL rstmid_stray: got %0d want 0", stray); end
    start = 1'b1; frame_len = 8'd6;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (addr_data !== 8'd0 || addr_factor !== 8'd24 || busy !== 1'b1) begin
      bad++; $display("FAIL rstmid_reprime: got ad=%0d af=%0d busy=%b want 0/24/1",
                      addr_data, addr_factor, busy);
    end
    out_tick = 1'b1;
    nv = 0;
    for (int c = 0; c < 300 && nd == 0; c++) begin
      if (out_valid) nv++;
      if (done) nd++;
      else @(negedge clk);
    end
    out_tick = 1'b0;
    total++;
    if (nv != 75 || nd != 1) begin
      bad++; $display("FAIL rstmid_refram: got valids=%0d done=%0d want 75/1", nv, nd);
    end
    @(negedge clk);
  endtask

  task automatic test_start_during_run();
    int nv, nd, stray;
    bit pulsed;
    nv = 0; nd = 0; stray = 0; pulsed = 1'b0;
    start = 1'b1; frame_len = 8'd6; out_tick = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 300 && nd == 0; c++) begin
      start = 1'b0;
      if (out_valid) nv++;
      if (nv == 20 && !pulsed) begin
        start = 1'b1; frame_len = 8'd4; pulsed = 1'b1;
      end
      if (done) nd++;
      else @(negedge clk);
    end
    start = 1'b0; out_tick = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || out_valid || busy) stray++;
    end
    total++;
    if (nv != 75) begin bad++; $display("FAIL busy_start_count: got %0d want 75", nv); end
    total++;
    if (nd != 1 || stray != 0) begin
      bad++; $display("FAIL busy_start_done: got done=%0d stray=%0d want 1/0", nd, stray);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_err();
    test_full_frame();
    test_sparse_ticks();
    test_datapath();
    test_reset_mid_frame();
    test_start_during_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
